multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle RV32 datapath. Sequences fetch, decode, execute, memory and writeback for the supported subset.
- It is the issuing side of the ALU-control interface: it produces ALU_Op and funct_field, and the ALU-control decoder consumes them.
- It also drives the datapath write enables and mux selects, a req/ready memory handshake, and a retired-instruction counter.

---
 rtl/control_pkg.sv | 125 ++++++++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 80 ++++++++
 tb/tb_multicycle_control.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control FSM.
// The ALU-control decoder imports the same ALU_Op and funct constants.
package control_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FUNCT_W = 4;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_WB_R      = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_WB_LOAD   = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'b0000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'b1000;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 4'b0111;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 4'b0110;

    typedef struct packed {
        logic               mem_req;
        logic               mem_we;
        logic               i_or_d;
        logic               pc_write_cond;
        logic               pc_source;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         alu_op;
        logic [FUNCT_W-1:0] funct_field;
        logic               reg_write;
        logic               mem_to_reg;
        logic               illegal;
    } ctrl_t;

    function automatic logic funct_legal(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) || (f == FUNCT_OR);
    endfunction

    // Opcode dispatch out of DECODE.
    function automatic state_t decode_next(input logic [INSTR_W-1:0] ins);
        state_t nxt;
        nxt = S_TRAP;
        if (ins[6:0] == OP_R)                                nxt = S_EXEC_R;
        else if (ins[6:0] == OP_LOAD   && ins[14:12] == F3_WORD) nxt = S_MEM_ADDR;
        else if (ins[6:0] == OP_STORE  && ins[14:12] == F3_WORD) nxt = S_MEM_ADDR;
        else if (ins[6:0] == OP_BRANCH && ins[14:12] == F3_BEQ)  nxt = S_BRANCH;
        return nxt;
    endfunction

    // State-only control word; handshake-gated strobes are produced separately.
    function automatic ctrl_t moore_ctrl(input state_t s, input logic [INSTR_W-1:0] ins);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_op      = ALUOP_RTYPE;
                c.funct_field = {ins[30], ins[14:12]};
            end
            S_WB_R: c.reg_write = 1'b1;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
            end
            S_WB_LOAD: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.i_or_d  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RS2;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
            end
            S_TRAP:  c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: IR/flag inputs, memory handshake, strobes and selects.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             i_or_d;
    logic             ir_write;
    logic             mdr_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       ALU_Op;
    logic [3:0]       funct_field;
    logic             reg_write;
    logic             mem_to_reg;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, ALU_Op, funct_field, reg_write,
               mem_to_reg, illegal, retired
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, ALU_Op, funct_field, reg_write,
               mem_to_reg, illegal, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32 datapath: fetch/decode/execute/memory/writeback
// sequencing, memory req/ready handshake and retired-instruction counter.
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.master bus
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             fetch_done, read_done;

    // Zero is qualified in the datapath; only opcode/funct bits steer control.
    logic unused_inputs;
    assign unused_inputs = ^{bus.zero, bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            retired_q <= retired_d;
        end
    end

    // Next state; outputs are registered from the state being entered.
    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = decode_next(bus.instr);
            S_EXEC_R:    state_d = funct_legal({bus.instr[30], bus.instr[14:12]}) ? S_WB_R : S_TRAP;
            S_WB_R:      state_d = S_FETCH;
            S_MEM_ADDR:  state_d = (bus.instr[6:0] == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_WB_LOAD;
            S_WB_LOAD:   state_d = S_FETCH;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
        ctrl_d = moore_ctrl(state_d, bus.instr);
        if (state_d == S_FETCH &&
            (state_q == S_WB_R || state_q == S_WB_LOAD ||
             state_q == S_MEM_WRITE || state_q == S_BRANCH)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign fetch_done = (state_q == S_FETCH) && bus.mem_ready;
    assign read_done  = (state_q == S_MEM_READ) && bus.mem_ready;

    assign bus.mem_req       = ctrl_q.mem_req;
    assign bus.mem_we        = ctrl_q.mem_we;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.ir_write      = fetch_done;
    assign bus.pc_write      = fetch_done;
    assign bus.mdr_write     = read_done;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.ALU_Op        = ctrl_q.alu_op;
    assign bus.funct_field   = ctrl_q.funct_field;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.illegal       = ctrl_q.illegal;
    assign bus.retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded random-instruction bench for multicycle_control.
module tb_multicycle_control;

    localparam int unsigned CNT_W   = 32;
    localparam int          N_RAND  = 40;
    localparam int          N_INSTR = N_RAND + 5;
    localparam int          BUDGET  = 60;

    logic clk = 1'b0;
    logic reset_n;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();
    multicycle_control #(.CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    typedef enum logic [1:0] {K_R, K_LW, K_SW, K_BEQ} kind_t;

    // Per-instruction observation window, from its ir_write to the next ir_write.
    typedef struct {
        int cyc; int stall; int ireq; int dreq; int we; int rw; int m2r;
        int mdr; int br; int rt; int funct; int pcw; int bad; int ret;
    } obs_t;

    obs_t        sb[$];
    int          total = 0;
    int          bad_n = 0;
    bit          mon_en = 1'b0;
    bit          abort = 1'b0;
    logic [31:0] iw [0:N_INSTR];
    kind_t       kd [0:N_INSTR];
    int          fw [0:N_INSTR];
    int          dw [0:N_INSTR];

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [19:0] out_vec();
        return {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.mdr_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.ALU_Op,
                bus.funct_field, bus.reg_write, bus.mem_to_reg, bus.illegal};
    endfunction

    // Instruction-level reference: what one instruction must show on the control bus.
    function automatic obs_t expect_for(input kind_t k, input logic [31:0] ins,
                                        input int dwk, input int fwn, input int ret);
        obs_t e;
        e       = '{default: 0};
        e.stall = dwk + fwn;
        e.ireq  = 1 + fwn;
        e.pcw   = 1;
        e.ret   = ret;
        case (k)
            K_R:   begin e.cyc = 4 + fwn; e.rw = 1; e.rt = 1; e.funct = int'({ins[30], ins[14:12]}); end
            K_LW:  begin e.cyc = 5 + dwk + fwn; e.dreq = dwk + 1; e.rw = 1; e.m2r = 1; e.mdr = 1; end
            K_SW:  begin e.cyc = 4 + dwk + fwn; e.dreq = dwk + 1; e.we = dwk + 1; end
            default: begin e.cyc = 3 + fwn; e.br = 1; end
        endcase
        return e;
    endfunction

    task automatic gen();
        logic [31:0] r;
        logic [3:0]  f;
        iw[0] = 32'h002081B3; kd[0] = K_R;   fw[0] = 0; dw[0] = 0;
        iw[1] = 32'h402081B3; kd[1] = K_R;   fw[1] = 3; dw[1] = 0;
        iw[2] = 32'h0000A183; kd[2] = K_LW;  fw[2] = 0; dw[2] = 2;
        iw[3] = 32'h0030A023; kd[3] = K_SW;  fw[3] = 0; dw[3] = 0;
        iw[4] = 32'h00208463; kd[4] = K_BEQ; fw[4] = 0; dw[4] = 0;
        for (int k = 5; k <= N_INSTR; k++) begin
            r     = $urandom;
            kd[k] = kind_t'($urandom_range(0, 3));
            fw[k] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            dw[k] = 0;
            case (kd[k])
                K_R: begin
                    case ($urandom_range(0, 3))
                        0: f = 4'b0000;
                        1: f = 4'b1000;
                        2: f = 4'b0111;
                        default: f = 4'b0110;
                    endcase
                    iw[k] = {1'b0, f[3], 5'b0, r[24:20], r[19:15], f[2:0], r[11:7], 7'b0110011};
                end
                K_LW:  iw[k] = {r[31:20], r[19:15], 3'b010, r[11:7], 7'b0000011};
                K_SW:  iw[k] = {r[31:25], r[24:20], r[19:15], 3'b010, r[11:7], 7'b0100011};
                default: iw[k] = {r[31:25], r[24:20], r[19:15], 3'b000, r[11:7], 7'b1100011};
            endcase
            if (kd[k] == K_LW || kd[k] == K_SW) dw[k] = int'($urandom_range(0, 3));
        end
        iw[N_INSTR] = 32'h0000007F;
    endtask

    // Monitor: accumulate per-window observations, compare on each new fetch.
    obs_t cur;
    bit   win_open = 1'b0;
    int   widx = 0;

    function automatic void close_window();
        obs_t e;
        if (sb.size() == 0) begin
            chk($sformatf("w%0d_sb_empty", widx), 1, 0);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("w%0d_cycles", widx), cur.cyc, e.cyc);
        chk($sformatf("w%0d_stalls", widx), cur.stall, e.stall);
        chk($sformatf("w%0d_fetch_req", widx), cur.ireq, e.ireq);
        chk($sformatf("w%0d_data_req", widx), cur.dreq, e.dreq);
        chk($sformatf("w%0d_mem_we", widx), cur.we, e.we);
        chk($sformatf("w%0d_reg_write", widx), cur.rw, e.rw);
        chk($sformatf("w%0d_mem_to_reg", widx), cur.m2r, e.m2r);
        chk($sformatf("w%0d_mdr_write", widx), cur.mdr, e.mdr);
        chk($sformatf("w%0d_branch", widx), cur.br, e.br);
        chk($sformatf("w%0d_rtype_op", widx), cur.rt, e.rt);
        chk($sformatf("w%0d_funct", widx), cur.funct, e.funct);
        chk($sformatf("w%0d_pc_write", widx), cur.pcw, e.pcw);
        chk($sformatf("w%0d_stray", widx), cur.bad, e.bad);
        chk($sformatf("w%0d_retired", widx), longint'(bus.retired), e.ret);
        widx++;
    endfunction

    always @(negedge clk) begin
        #2;
        if (!mon_en) begin
            win_open = 1'b0;
        end else begin
            if (bus.ir_write) begin
                if (win_open) close_window();
                win_open = 1'b1;
                cur = '{default: 0};
            end
            if (win_open) begin
                cur.cyc++;
                cur.stall += int'(bus.mem_req & ~bus.mem_ready);
                cur.ireq  += int'(bus.mem_req & ~bus.i_or_d & ~bus.mem_we & ~bus.alu_src_a &
                                  (bus.alu_src_b == 2'b01) & (bus.ALU_Op == 2'b00));
                cur.dreq  += int'(bus.mem_req & bus.i_or_d);
                cur.we    += int'(bus.mem_req & bus.mem_we);
                cur.rw    += int'(bus.reg_write);
                cur.m2r   += int'(bus.reg_write & bus.mem_to_reg);
                cur.mdr   += int'(bus.mdr_write);
                cur.br    += int'(bus.pc_write_cond & bus.pc_source & bus.alu_src_a &
                                  (bus.alu_src_b == 2'b00) & (bus.ALU_Op == 2'b01));
                cur.rt    += int'(bus.alu_src_a & (bus.alu_src_b == 2'b00) & (bus.ALU_Op == 2'b10));
                if (bus.ALU_Op == 2'b10) cur.funct = int'(bus.funct_field);
                cur.pcw   += int'(bus.pc_write & ~bus.pc_source);
                cur.bad   += int'((bus.ALU_Op == 2'b11) | bus.illegal |
                                  ((bus.ALU_Op != 2'b10) && (bus.funct_field != 4'b0000)));
            end
        end
    end

    // Wait for a request on the given side; idle cycles drive junk mem_ready.
    task automatic wait_req(input bit dside, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (bus.mem_req && bus.i_or_d == dside) begin
                ok = 1'b1;
                break;
            end
            bus.mem_ready = 1'($urandom);
        end
        if (!ok) chk("req_timeout", 0, 1);
    endtask

    task automatic serve(input int waits);
        bus.mem_ready = 1'b0;
        repeat (waits) @(negedge clk);
        bus.mem_ready = 1'b1;
    endtask

    task automatic wait_illegal();
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (bus.illegal) break;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("reset_outputs", longint'(out_vec()), 0);
        chk("reset_retired", longint'(bus.retired), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : main
        bit ok;
        bus.instr     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        reset_n       = 1'b0;
        gen();
        repeat (3) @(negedge clk);
        #1;
        chk("por_outputs", longint'(out_vec()), 0);
        chk("por_retired", longint'(bus.retired), 0);
        mon_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle_outputs", longint'(out_vec()), 0);

        for (int k = 0; k <= N_INSTR; k++) begin
            wait_req(1'b0, ok);
            if (!ok) begin abort = 1'b1; break; end
            bus.instr = iw[k];
            bus.zero  = 1'($urandom);
            if (k < N_INSTR) sb.push_back(expect_for(kd[k], iw[k], dw[k], fw[k+1], k + 1));
            serve(fw[k]);
            if (k < N_INSTR && (kd[k] == K_LW || kd[k] == K_SW)) begin
                wait_req(1'b1, ok);
                if (!ok) begin abort = 1'b1; break; end
                serve(dw[k]);
            end
        end

        if (!abort) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            mon_en        = 1'b0;
            chk("sb_drained", sb.size(), 0);
            wait_illegal();
            chk("trap_opcode", bus.illegal, 1);
            chk("trap_retired", longint'(bus.retired), N_INSTR);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                bus.mem_ready = 1'b1;
                #1;
                chk("trap_sticky", {bus.illegal, bus.mem_req, bus.reg_write, bus.ir_write, bus.mdr_write}, 5'b10000);
            end

            pulse_reset();
            wait_req(1'b0, ok);
            bus.instr = 32'h002091B3;
            serve(0);
            @(negedge clk);
            bus.mem_ready = 1'b0;
            wait_illegal();
            chk("trap_funct", bus.illegal, 1);

            pulse_reset();
            wait_req(1'b0, ok);
            bus.instr = 32'h0030A023;
            serve(0);
            wait_req(1'b1, ok);
            serve(0);
            wait_req(1'b0, ok);
            chk("sw_retired", longint'(bus.retired), 1);
            bus.instr = 32'h0000A183;
            serve(0);
            wait_req(1'b1, ok);
            bus.mem_ready = 1'b0;
            #2;
            reset_n = 1'b0;
            #1;
            chk("midread_req", bus.mem_req, 0);
            chk("midread_mdr", bus.mdr_write, 0);
            chk("midread_retired", longint'(bus.retired), 0);
            @(negedge clk);
            reset_n = 1'b1;
            #1;
            chk("post_reset_idle", bus.mem_req, 0);
            @(negedge clk);
            #1;
            chk("post_reset_fetch", {bus.mem_req, bus.i_or_d}, 2'b10);
        end

        $display("test done: total=%0d bad=%0d", total, bad_n);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
